// File: rtl/hockey_input_arbiter.sv
// hockey_input_arbiter: front end for the air-hockey game FSM.
// Debounces both player buttons and turns each debounced press into a one-deep
// per-player request holding {y, dir}. The two requests are merged round-robin
// into one valid/consume event stream. A free-running tick enable paces the
// game timers.
//
// Optional feature: define HOCKEY_Y_CLAMP_EN to clamp y > 4 to 4 and accept
// the press; without it, a press with y > 4 is discarded and evt_drop pulses.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   btn_a_raw/btn_b_raw raw (already synchronised) buttons
//   y_in_a/y_in_b       paddle Y, sampled on press
//   dir_a/dir_b         direction, sampled on press
//   consume             game FSM accepts the current event
//   tick_restart        restart the tick counter
//   btn_a_lvl/btn_b_lvl debounced levels
//   evt_valid/evt_player/evt_y/evt_dir  current event (player 0 = A, 1 = B)
//   evt_drop            1-cycle pulse when a press was discarded
//   tick                1-cycle game tick pulse
module hockey_input_arbiter #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned TICK_DIV   = 8,
    parameter int unsigned CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_a_raw,
    input  logic       btn_b_raw,
    input  logic [2:0] y_in_a,
    input  logic [2:0] y_in_b,
    input  logic [1:0] dir_a,
    input  logic [1:0] dir_b,
    input  logic       consume,
    input  logic       tick_restart,
    output logic       btn_a_lvl,
    output logic       btn_b_lvl,
    output logic       evt_valid,
    output logic       evt_player,
    output logic [2:0] evt_y,
    output logic [1:0] evt_dir,
    output logic       evt_drop,
    output logic       tick
);

    localparam int unsigned Y_W   = 3;
    localparam int unsigned DIR_W = 2;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(4);

    // index 0 = player A, 1 = player B
    logic [1:0]       raw;
    logic [1:0]       lvl;
    logic [1:0]       lvl_prev;
    logic [CNT_W-1:0] deb_cnt [2];

    logic [1:0]       pend;
    logic [Y_W-1:0]   slot_y   [2];
    logic [DIR_W-1:0] slot_dir [2];
    logic             last_grant;

    logic [Y_W-1:0]   y_raw   [2];
    logic [DIR_W-1:0] dir_raw [2];
    logic [Y_W-1:0]   y_cap   [2];
    logic [1:0]       y_ok;
    logic [1:0]       press;
    logic [1:0]       store;
    logic [1:0]       drop;
    logic [1:0]       free;
    logic             load;
    logic             do_grant;
    logic             gnt;

    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] tick_cnt_nxt;

    assign raw       = {btn_b_raw, btn_a_raw};
    assign btn_a_lvl = lvl[0];
    assign btn_b_lvl = lvl[1];

    // Debounce: lvl flips after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl      <= '0;
            lvl_prev <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            lvl_prev <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (raw[i] != lvl[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        lvl[i]     <= ~lvl[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Press detection, Y validation, round-robin grant and slot bookkeeping.
    always_comb begin
        y_raw[0]   = y_in_a;
        y_raw[1]   = y_in_b;
        dir_raw[0] = dir_a;
        dir_raw[1] = dir_b;
        press      = lvl & ~lvl_prev;
        free       = '0;
        store      = '0;
        drop       = '0;
        gnt        = 1'b0;
        for (int i = 0; i < 2; i++) begin
`ifdef HOCKEY_Y_CLAMP_EN
            y_ok[i]  = 1'b1;
            y_cap[i] = (y_raw[i] > Y_MAX) ? Y_MAX : y_raw[i];
`else
            y_ok[i]  = (y_raw[i] <= Y_MAX);
            y_cap[i] = y_raw[i];
`endif
        end
        load = ~evt_valid | consume;
        // Both pending: favour the player not granted last time.
        if (pend[0] && pend[1]) gnt = ~last_grant;
        else if (pend[1])       gnt = 1'b1;
        do_grant = load & (|pend);
        if (do_grant) free[gnt] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            // A slot freed on this edge may take the new press.
            store[i] = press[i] & y_ok[i] & (~pend[i] | free[i]);
            drop[i]  = press[i] & ~store[i];
        end
    end

    // One-deep request slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            for (int i = 0; i < 2; i++) begin
                slot_y[i]   <= '0;
                slot_dir[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (store[i]) begin
                    pend[i]     <= 1'b1;
                    slot_y[i]   <= y_cap[i];
                    slot_dir[i] <= dir_raw[i];
                end else if (free[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    // Event output register; fields hold while valid and not consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid  <= 1'b0;
            evt_player <= 1'b0;
            evt_y      <= '0;
            evt_dir    <= '0;
            evt_drop   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            evt_drop <= |drop;
            if (load) begin
                if (do_grant) begin
                    evt_valid  <= 1'b1;
                    evt_player <= gnt;
                    evt_y      <= slot_y[gnt];
                    evt_dir    <= slot_dir[gnt];
                    last_grant <= gnt;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

    // Tick counter; restart beats the wrap.
    always_comb begin
        tick_cnt_nxt = tick_cnt + CNT_W'(1);
        if (tick_restart)               tick_cnt_nxt = '0;
        else if (tick_cnt == TICK_LAST) tick_cnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt_nxt;
            tick     <= (tick_cnt_nxt == TICK_LAST);
        end
    end

endmodule

// File: tb/tb_hockey_input_arbiter.sv
// Directed bench for hockey_input_arbiter (DEB_CYCLES=4, TICK_DIV=8).
module tb_hockey_input_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_a_raw, btn_b_raw;
    logic [2:0] y_in_a, y_in_b;
    logic [1:0] dir_a, dir_b;
    logic       consume, tick_restart;
    logic       btn_a_lvl, btn_b_lvl;
    logic       evt_valid, evt_player;
    logic [2:0] evt_y;
    logic [1:0] evt_dir;
    logic       evt_drop, tick;

    int compared   = 0;
    int mismatched = 0;

    hockey_input_arbiter #(.DEB_CYCLES(4), .TICK_DIV(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .btn_a_raw(btn_a_raw), .btn_b_raw(btn_b_raw),
        .y_in_a(y_in_a), .y_in_b(y_in_b),
        .dir_a(dir_a), .dir_b(dir_b),
        .consume(consume), .tick_restart(tick_restart),
        .btn_a_lvl(btn_a_lvl), .btn_b_lvl(btn_b_lvl),
        .evt_valid(evt_valid), .evt_player(evt_player),
        .evt_y(evt_y), .evt_dir(evt_dir),
        .evt_drop(evt_drop), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
    endtask

    // Player A press: raw high 4 samples, returns just after the slot-capture edge.
    task automatic press_a(input logic [2:0] y, input logic [1:0] d, input logic cons);
        y_in_a    = y;
        dir_a     = d;
        btn_a_raw = 1'b1;
        step(4);
        btn_a_raw = 1'b0;
        consume   = cons;
        step(1);
        consume   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        btn_a_raw = 0; btn_b_raw = 0;
        y_in_a = 0; y_in_b = 0; dir_a = 0; dir_b = 0;
        consume = 0; tick_restart = 0;
        step(2);
        chk("rst_valid", 8'(evt_valid), 8'd0);
        chk("rst_tick",  8'(tick), 8'd0);
        chk("rst_lvl",   8'({btn_a_lvl, btn_b_lvl}), 8'd0);
        chk("rst_drop",  8'(evt_drop), 8'd0);
        chk("rst_y",     8'(evt_y), 8'd0);
        rst = 1'b0;
        step(1);

        // 1: 3-cycle glitch never flips lvl
        btn_a_raw = 1'b1;
        step(3);
        btn_a_raw = 1'b0;
        step(1);
        chk("glitch_lvl", 8'(btn_a_lvl), 8'd0);
        step(4);
        chk("glitch_valid", 8'(evt_valid), 8'd0);

        // 2: B press latency and hold
        y_in_b = 3'd2; dir_b = 2'b01; btn_b_raw = 1'b1;
        step(3);
        chk("b_lvl_e3", 8'(btn_b_lvl), 8'd0);
        step(1);
        chk("b_lvl_e4", 8'(btn_b_lvl), 8'd1);
        chk("b_valid_e4", 8'(evt_valid), 8'd0);
        step(1);
        chk("b_valid_e5", 8'(evt_valid), 8'd0);
        step(1);
        chk("b_valid_e6", 8'(evt_valid), 8'd1);
        chk("b_player", 8'(evt_player), 8'd1);
        chk("b_y", 8'(evt_y), 8'd2);
        chk("b_dir", 8'(evt_dir), 8'd1);
        y_in_b = 3'd3;
        step(4);
        btn_b_raw = 1'b0;
        chk("b_hold_valid", 8'(evt_valid), 8'd1);
        chk("b_hold_y", 8'(evt_y), 8'd2);
        step(4);
        chk("b_lvl_fall", 8'(btn_b_lvl), 8'd0);
        chk("b_still_valid", 8'(evt_valid), 8'd1);
        consume = 1'b1;
        step(1);
        consume = 1'b0;
        chk("b_consumed", 8'(evt_valid), 8'd0);
        step(1);

        // 3: simultaneous A/B after reset -> A then B back-to-back
        do_reset();
        y_in_a = 3'd1; dir_a = 2'b10; y_in_b = 3'd3; dir_b = 2'b00;
        btn_a_raw = 1'b1; btn_b_raw = 1'b1;
        step(4);
        btn_a_raw = 1'b0; btn_b_raw = 1'b0;
        step(1);
        chk("rr_valid_e5", 8'(evt_valid), 8'd0);
        step(1);
        chk("rr_first", 8'({evt_valid, evt_player, evt_y, evt_dir}), 8'b1_0_001_10);
        consume = 1'b1;
        step(1);
        chk("rr_second", 8'({evt_valid, evt_player, evt_y, evt_dir}), 8'b1_1_011_00);
        step(1);
        consume = 1'b0;
        chk("rr_empty", 8'(evt_valid), 8'd0);
        step(2);

        // 4: slot fill, overflow drop, free-and-store on same edge
        do_reset();
        press_a(3'd1, 2'b01, 1'b0);
        chk("p1_drop", 8'(evt_drop), 8'd0);
        chk("p1_valid", 8'(evt_valid), 8'd0);
        step(1);
        chk("p1_evt", 8'({evt_valid, evt_player, evt_y, evt_dir}), 8'b1_0_001_01);
        step(3);
        press_a(3'd2, 2'b10, 1'b0);
        chk("p2_drop", 8'(evt_drop), 8'd0);
        chk("p2_held_y", 8'(evt_y), 8'd1);
        step(4);
        press_a(3'd3, 2'b00, 1'b0);
        chk("p3_drop", 8'(evt_drop), 8'd1);
        chk("p3_held_y", 8'(evt_y), 8'd1);
        step(1);
        chk("p3_drop_pulse", 8'(evt_drop), 8'd0);
        step(3);
        press_a(3'd4, 2'b01, 1'b1);
        chk("p4_drop", 8'(evt_drop), 8'd0);
        chk("p4_evt_slot2", 8'({evt_valid, evt_y, evt_dir}), 8'b000_1_010_10);
        step(1);
        chk("p4_hold", 8'(evt_y), 8'd2);
        consume = 1'b1;
        step(1);
        chk("p4_evt_slot4", 8'({evt_valid, evt_y, evt_dir}), 8'b000_1_100_01);
        step(1);
        consume = 1'b0;
        chk("p4_empty", 8'(evt_valid), 8'd0);
        step(3);

        // 5: out-of-range Y
        do_reset();
        press_a(3'd6, 2'b01, 1'b0);
`ifdef HOCKEY_Y_CLAMP_EN
        chk("y6_drop", 8'(evt_drop), 8'd0);
        step(1);
        chk("y6_evt", 8'({evt_valid, evt_y}), 8'b0000_1_100);
        consume = 1'b1;
        step(1);
        consume = 1'b0;
`else
        chk("y6_drop", 8'(evt_drop), 8'd1);
        step(1);
        chk("y6_no_evt", 8'(evt_valid), 8'd0);
        step(1);
`endif
        step(3);

        // 6: tick period and restart
        tick_restart = 1'b1;
        step(1);
        tick_restart = 1'b0;
        chk("tick_restart0", 8'(tick), 8'd0);
        step(6);
        chk("tick_c6", 8'(tick), 8'd0);
        step(1);
        chk("tick_c7", 8'(tick), 8'd1);
        step(1);
        chk("tick_width", 8'(tick), 8'd0);
        step(5);
        tick_restart = 1'b1;
        step(1);
        tick_restart = 1'b0;
        step(6);
        chk("tick_after_rs6", 8'(tick), 8'd0);
        step(1);
        chk("tick_after_rs7", 8'(tick), 8'd1);

        // reset mid-event clears event and tick at once
        press_a(3'd2, 2'b00, 1'b0);
        step(1);
        chk("mid_valid", 8'(evt_valid), 8'd1);
        tick_restart = 1'b1;
        step(1);
        tick_restart = 1'b0;
        step(7);
        chk("mid_tick", 8'(tick), 8'd1);
        chk("mid_valid2", 8'(evt_valid), 8'd1);
        rst = 1'b1;
        #1;
        chk("async_valid", 8'(evt_valid), 8'd0);
        chk("async_tick", 8'(tick), 8'd0);
        step(1);
        rst = 1'b0;
        step(8);
        chk("post_rst_valid", 8'(evt_valid), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
